// File: rtl/otp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : otp_pkg
// Description : Shared sizes and word types for the one-time-pad cryptor.
// Revision    : 1.0 - initial release
// ============================================================================
package otp_pkg;

    localparam int KEY_SIZE   = 16;
    localparam int MSG_SIZE   = 240;
    localparam int MSG_BLOCKS = MSG_SIZE / KEY_SIZE;

    typedef logic [KEY_SIZE-1:0] key_word_t;
    typedef logic [KEY_SIZE-1:0] msg_word_t;

endpackage : otp_pkg
`default_nettype wire

// File: rtl/otp_key_fifo.sv
`default_nettype none
// ============================================================================
// Module      : otp_key_fifo
// Description : Key FIFO; a slot is cleared as soon as its word is popped.
// Revision    : 1.0 - initial release
// ============================================================================
module otp_key_fifo
    import otp_pkg::*;
#(
    parameter int DATA_W = KEY_SIZE,
    parameter int DEPTH  = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_push;
    logic              w_pop;

    // Pointers can only coincide when empty or full, so push and pop never
    // target the same slot in one cycle.
    assign w_push = push && !full;
    assign w_pop  = pop  && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_mem[r_rd_ptr] <= '0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign level = r_level;
    assign full  = (r_level == LVL_W'(DEPTH));
    assign empty = (r_level == '0);

endmodule : otp_key_fifo
`default_nettype wire

// File: rtl/otp_stream_cryptor.sv
`default_nettype none
// ============================================================================
// Module      : otp_stream_cryptor
// Description : Streaming one-time-pad XOR cryptor with a key FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module otp_stream_cryptor
    import otp_pkg::*;
#(
    parameter int BLOCK_W    = KEY_SIZE,
    parameter int MSG_BLOCKS = otp_pkg::MSG_BLOCKS,
    parameter int KEY_DEPTH  = 16
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BLOCK_W-1:0]         key_in,
    input  logic                       key_valid,
    output logic                       key_ready,
    input  logic [BLOCK_W-1:0]         in_data,
    input  logic                       in_last,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [BLOCK_W-1:0]         out_data,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(KEY_DEPTH):0] key_level,
    output logic                       frame_err
);

    localparam int                CNT_W      = $clog2(MSG_BLOCKS + 1);
    localparam logic [CNT_W-1:0] c_last_blk = CNT_W'(MSG_BLOCKS - 1);

    logic [BLOCK_W-1:0] w_key_head;
    logic               w_key_full;
    logic               w_key_empty;
    logic               w_accept;
    logic               w_at_last;

    logic [BLOCK_W-1:0] r_out_data;
    logic               r_out_last;
    logic               r_out_valid;
    logic [CNT_W-1:0]   r_blk_cnt;
    logic               r_frame_err;

    assign key_ready = !w_key_full;
    // A word is only taken when a key is already stored: no bypass, no stale key.
    assign in_ready  = !w_key_empty && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_at_last = (r_blk_cnt == c_last_blk);

    otp_key_fifo #(
        .DATA_W (BLOCK_W),
        .DEPTH  (KEY_DEPTH)
    ) u_key_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (key_valid),
        .din   (key_in),
        .pop   (w_accept),
        .dout  (w_key_head),
        .level (key_level),
        .full  (w_key_full),
        .empty (w_key_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_blk_cnt   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_data  <= in_data ^ w_key_head;
                r_out_last  <= w_at_last;
                r_out_valid <= 1'b1;
                r_blk_cnt   <= (w_at_last || in_last) ? '0 : r_blk_cnt + 1'b1;
                if (in_last != w_at_last) begin
                    r_frame_err <= 1'b1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;

endmodule : otp_stream_cryptor
`default_nettype wire

// File: tb/tb_otp_stream_cryptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_otp_stream_cryptor
// Description : Scoreboard bench for otp_stream_cryptor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otp_stream_cryptor;
    import otp_pkg::*;

    localparam int KD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    key_word_t   key_in = '0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    msg_word_t   in_data = '0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    msg_word_t   out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  key_level;
    logic        frame_err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        key_word_t data;
        logic      last;
    } exp_t;

    key_word_t kq[$];
    exp_t      sb[$];
    int        m_cnt  = 0;
    logic      m_ferr = 1'b0;
    logic      m_ov   = 1'b0;
    logic      m_acc;
    key_word_t m_k;
    exp_t      m_e;

    always #5 clk = ~clk;

    otp_stream_cryptor #(
        .BLOCK_W    (KEY_SIZE),
        .MSG_BLOCKS (MSG_BLOCKS),
        .KEY_DEPTH  (KD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .key_level (key_level),
        .frame_err (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model and scoreboard, evaluated between rising edges.
    always @(negedge clk) begin
        if (rst) begin
            kq.delete();
            sb.delete();
            m_cnt  = 0;
            m_ferr = 1'b0;
            m_ov   = 1'b0;
        end else begin
            check("key_level", 32'(key_level), 32'(kq.size()));
            check("key_ready", 32'(key_ready), 32'(kq.size() != KD));
            check("in_ready",  32'(in_ready),  32'((kq.size() != 0) && (!m_ov || out_ready)));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("frame_err", 32'(frame_err), 32'(m_ferr));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 32'(sb.size()), 32'd1);
                end else begin
                    check("out_data", 32'(out_data), 32'(sb[0].data));
                    check("out_last", 32'(out_last), 32'(sb[0].last));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            m_acc = in_valid && in_ready;
            if (m_acc) begin
                if (kq.size() == 0) begin
                    check("pop_empty", 32'(kq.size()), 32'd1);
                end else begin
                    m_k    = kq.pop_front();
                    m_e.data = in_data ^ m_k;
                    m_e.last = (m_cnt == MSG_BLOCKS - 1);
                    sb.push_back(m_e);
                end
                if (in_last != (m_cnt == MSG_BLOCKS - 1)) m_ferr = 1'b1;
                m_cnt = (in_last || m_cnt == MSG_BLOCKS - 1) ? 0 : m_cnt + 1;
            end
            if (key_valid && key_ready) kq.push_back(key_in);
            m_ov = m_acc ? 1'b1 : (out_ready ? 1'b0 : m_ov);
        end
    end

    task automatic check_reset_state();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_key_level", 32'(key_level), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_key_ready", 32'(key_ready), 32'd1);
        check("rst_in_ready",  32'(in_ready),  32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; key_valid = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state();
    endtask

    task automatic push_key(input key_word_t k);
        int t = 0;
        key_in = k; key_valid = 1'b1;
        @(negedge clk);
        while (!key_ready && t < 200) begin @(negedge clk); t++; end
        if (!key_ready) check("push_timeout", 32'(key_ready), 32'd1);
        @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    task automatic send_word(input msg_word_t d, input logic last);
        int t = 0;
        in_data = d; in_last = last; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 100) begin @(negedge clk); t++; end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Basic cipher
        push_key(16'hA5A5);
        send_word(16'h1234, 1'b0);
        check("basic_data",  32'(out_data),  32'h0000B791);
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_level", 32'(key_level), 32'd0);
        wait_drain();

        // Full message
        do_reset();
        for (int i = 0; i < MSG_BLOCKS; i++) push_key(key_word_t'(16'h1000 + i));
        for (int i = 0; i < MSG_BLOCKS; i++) send_word(msg_word_t'(i), i == MSG_BLOCKS - 1);
        wait_drain();
        check("msg_frame_err", 32'(frame_err), 32'd0);

        // Key starvation
        do_reset();
        in_data = 16'hBEEF; in_last = 1'b0; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("starve_in_ready",  32'(in_ready),  32'd0);
            check("starve_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        push_key(16'h0F0F);
        check("starve_wake", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("starve_data", 32'(out_data), 32'h0000B1E0);
        wait_drain();

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_key(key_word_t'(16'h3100 + 16'(i * 7)));
        fork
            begin
                for (int i = 0; i < 4; i++) send_word(msg_word_t'(16'h4000 + i), 1'b0);
            end
            begin
                int t = 0;
                @(negedge clk);
                while (!out_valid && t < 50) begin @(negedge clk); t++; end
                check("bp_first_valid", 32'(out_valid), 32'd1);
                for (int c = 0; c < 3; c++) begin
                    if (c > 0) @(negedge clk);
                    check("bp_in_ready", 32'(in_ready),  32'd0);
                    check("bp_level",    32'(key_level), 32'd3);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // FIFO full
        do_reset();
        for (int i = 0; i < KD; i++) push_key(key_word_t'(16'h2000 + i));
        check("full_level", 32'(key_level), 32'd16);
        check("full_ready", 32'(key_ready), 32'd0);
        fork
            push_key(16'h2010);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("full_hold_ready", 32'(key_ready), 32'd0);
                    check("full_hold_level", 32'(key_level), 32'd16);
                end
                @(posedge clk);
                #1;
                send_word(16'h5555, 1'b0);
            end
        join
        check("full_refill", 32'(key_level), 32'd16);
        for (int i = 0; i < KD; i++) send_word(msg_word_t'(16'h6000 + i), i == MSG_BLOCKS - 2);
        wait_drain();

        // Frame error, then reset mid-stream
        do_reset();
        for (int i = 0; i < 6; i++) push_key(key_word_t'(16'h0A0A * (i + 1)));
        for (int i = 0; i < 5; i++) send_word(msg_word_t'(16'h0300 + i), i == 3);
        wait_drain();
        check("ferr_set", 32'(frame_err), 32'd1);
        push_key(16'h1111);
        push_key(16'h2222);
        in_data = 16'h7777; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_otp_stream_cryptor
`default_nettype wire
